// File: rtl/hazard_pkg.sv
// Shared types and defaults for the branch hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN = 1'b0,
        S1  = 1'b1
    } state_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush sequencer for ID-resolved beq: hazard detection, bubbles,
// branch operand forwarding selects and saturating stall/flush statistics.
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Ra,
    input  logic [4:0]       id_Rb,
    input  logic             id_Branch,
    input  logic             id_UsesRa,
    input  logic             id_UsesRb,
    input  logic [4:0]       ex_Rw,
    input  logic [4:0]       mem_Rw,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic             mem_RegWr,
    input  logic             mem_MemtoReg,
    input  logic             branch_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             BranchForwardA,
    output logic             BranchForwardB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e r_state;
    state_e w_next_state;
    logic   w_stall;
    logic   w_hit_ex;
    logic   w_hit_mem;
    logic   w_h2;
    logic   w_h1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_stall        = 1'b0;
        w_hit_ex       = (id_UsesRa && ex_Rw != 5'd0 && ex_Rw == id_Ra) ||
                         (id_UsesRb && ex_Rw != 5'd0 && ex_Rw == id_Rb);
        w_hit_mem      = (id_UsesRa && mem_Rw != 5'd0 && mem_Rw == id_Ra) ||
                         (id_UsesRb && mem_Rw != 5'd0 && mem_Rw == id_Rb);
        w_h2           = id_Branch && ex_RegWr && ex_MemtoReg && w_hit_ex;
        w_h1           = (id_Branch && ex_RegWr && !ex_MemtoReg && w_hit_ex) ||
                         (id_Branch && mem_RegWr && mem_MemtoReg && w_hit_mem) ||
                         (!id_Branch && ex_RegWr && ex_MemtoReg && w_hit_ex);

        unique case (r_state)
            RUN: begin
                w_stall = w_h2 || w_h1;
                // A load feeding beq needs a second cycle until it reaches WB.
                if (w_h2) begin
                    w_next_state = S1;
                end
            end
            S1: begin
                w_stall      = 1'b1;
                w_next_state = RUN;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase

        pc_stall       = w_stall;
        ifid_stall     = w_stall;
        idex_bubble    = w_stall;
        ifid_flush     = id_Branch && branch_taken && !w_stall;
        BranchForwardA = mem_RegWr && !mem_MemtoReg && mem_Rw != 5'd0 && mem_Rw == id_Ra;
        BranchForwardB = mem_RegWr && !mem_MemtoReg && mem_Rw != 5'd0 && mem_Rw == id_Rb;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall),
        .q   (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; a second CNT_W=2 instance shares inputs.
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_Ra, id_Rb, ex_Rw, mem_Rw;
    logic        id_Branch, id_UsesRa, id_UsesRb;
    logic        ex_RegWr, ex_MemtoReg, mem_RegWr, mem_MemtoReg, branch_taken;
    logic        pc_stall, ifid_stall, idex_bubble, ifid_flush;
    logic        bfa, bfb;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_stall, s_ifid_stall, s_idex_bubble, s_ifid_flush, s_bfa, s_bfb;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_Ra          (id_Ra),
        .id_Rb          (id_Rb),
        .id_Branch      (id_Branch),
        .id_UsesRa      (id_UsesRa),
        .id_UsesRb      (id_UsesRb),
        .ex_Rw          (ex_Rw),
        .mem_Rw         (mem_Rw),
        .ex_RegWr       (ex_RegWr),
        .ex_MemtoReg    (ex_MemtoReg),
        .mem_RegWr      (mem_RegWr),
        .mem_MemtoReg   (mem_MemtoReg),
        .branch_taken   (branch_taken),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .idex_bubble    (idex_bubble),
        .ifid_flush     (ifid_flush),
        .BranchForwardA (bfa),
        .BranchForwardB (bfb),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    branch_hazard_ctrl #(
        .CNT_W (2)
    ) dut_small (
        .clk            (clk),
        .rst            (rst),
        .id_Ra          (id_Ra),
        .id_Rb          (id_Rb),
        .id_Branch      (id_Branch),
        .id_UsesRa      (id_UsesRa),
        .id_UsesRb      (id_UsesRb),
        .ex_Rw          (ex_Rw),
        .mem_Rw         (mem_Rw),
        .ex_RegWr       (ex_RegWr),
        .ex_MemtoReg    (ex_MemtoReg),
        .mem_RegWr      (mem_RegWr),
        .mem_MemtoReg   (mem_MemtoReg),
        .branch_taken   (branch_taken),
        .pc_stall       (s_pc_stall),
        .ifid_stall     (s_ifid_stall),
        .idex_bubble    (s_idex_bubble),
        .ifid_flush     (s_ifid_flush),
        .BranchForwardA (s_bfa),
        .BranchForwardB (s_bfb),
        .stall_cnt      (s_stall_cnt),
        .flush_cnt      (s_flush_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // All three stall outputs must agree with the expected stall.
    task automatic chk_stall(input string tag, input int exp);
        chk({tag, ".pc_stall"}, int'(pc_stall), exp);
        chk({tag, ".ifid_stall"}, int'(ifid_stall), exp);
        chk({tag, ".idex_bubble"}, int'(idex_bubble), exp);
    endtask

    task automatic idle();
        id_Ra = 0; id_Rb = 0; ex_Rw = 0; mem_Rw = 0;
        id_Branch = 0; id_UsesRa = 0; id_UsesRb = 0;
        ex_RegWr = 0; ex_MemtoReg = 0; mem_RegWr = 0; mem_MemtoReg = 0;
        branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beq(input logic [4:0] ra, input logic [4:0] rb, input logic taken);
        id_Branch = 1; id_UsesRa = 1; id_UsesRb = 1;
        id_Ra = ra; id_Rb = rb; branch_taken = taken;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        chk_stall("reset", 0);
        chk("reset.flush", int'(ifid_flush), 0);
        chk("reset.stall_cnt", int'(stall_cnt), 0);
        chk("reset.flush_cnt", int'(flush_cnt), 0);

        // lw r1 in EX, beq r1,r2 in ID: two stall cycles
        beq(5'd1, 5'd2, 1'b0);
        ex_Rw = 1; ex_RegWr = 1; ex_MemtoReg = 1;
        #1;
        chk_stall("lw_beq.c0", 1);
        tick();
        ex_Rw = 0; ex_RegWr = 0; ex_MemtoReg = 0;
        mem_Rw = 1; mem_RegWr = 1; mem_MemtoReg = 1;
        #1;
        chk_stall("lw_beq.c1", 1);
        chk("lw_beq.c1.bfa", int'(bfa), 0);
        tick();
        mem_Rw = 0; mem_RegWr = 0; mem_MemtoReg = 0;
        #1;
        chk_stall("lw_beq.c2", 0);
        chk("lw_beq.c2.bfa", int'(bfa), 0);
        chk("lw_beq.stall_cnt", int'(stall_cnt), 2);

        // add r2 in EX, beq r3,r2 in ID: one stall, then forward B from MEM
        idle();
        beq(5'd3, 5'd2, 1'b0);
        ex_Rw = 2; ex_RegWr = 1;
        #1;
        chk_stall("alu_beq.c0", 1);
        tick();
        ex_Rw = 0; ex_RegWr = 0;
        mem_Rw = 2; mem_RegWr = 1;
        #1;
        chk_stall("alu_beq.c1", 0);
        chk("alu_beq.bfb", int'(bfb), 1);
        chk("alu_beq.bfa", int'(bfa), 0);
        chk("alu_beq.stall_cnt", int'(stall_cnt), 3);

        // lw r4 in MEM feeding beq in ID stalls too
        idle();
        beq(5'd5, 5'd4, 1'b0);
        mem_Rw = 4; mem_RegWr = 1; mem_MemtoReg = 1;
        #1;
        chk_stall("mem_lw_beq", 1);
        chk("mem_lw_beq.bfb", int'(bfb), 0);
        tick();
        chk("mem_lw_beq.stall_cnt", int'(stall_cnt), 4);

        // lw r3 in EX, add using r3 in ID: one cycle load-use stall
        idle();
        id_Ra = 3; id_UsesRa = 1;
        ex_Rw = 3; ex_RegWr = 1; ex_MemtoReg = 1;
        #1;
        chk_stall("loaduse.c0", 1);
        tick();
        ex_Rw = 0; ex_RegWr = 0; ex_MemtoReg = 0;
        mem_Rw = 3; mem_RegWr = 1; mem_MemtoReg = 1;
        #1;
        chk_stall("loaduse.c1", 0);
        chk("loaduse.stall_cnt", int'(stall_cnt), 5);
        idle();
        id_Ra = 0; id_UsesRa = 1;
        ex_Rw = 0; ex_RegWr = 1; ex_MemtoReg = 1;
        #1;
        chk_stall("loaduse.r0", 0);

        // Taken branch, no hazard: single flush
        idle();
        beq(5'd6, 5'd7, 1'b1);
        #1;
        chk("taken.flush", int'(ifid_flush), 1);
        chk_stall("taken", 0);
        tick();
        idle();
        #1;
        chk("taken.flush_cnt", int'(flush_cnt), 1);
        chk("taken.flush_after", int'(ifid_flush), 0);

        // Taken branch under H2: no flush until stall ends
        beq(5'd8, 5'd9, 1'b1);
        ex_Rw = 8; ex_RegWr = 1; ex_MemtoReg = 1;
        #1;
        chk("h2_taken.c0.flush", int'(ifid_flush), 0);
        tick();
        ex_Rw = 0; ex_RegWr = 0; ex_MemtoReg = 0;
        #1;
        chk("h2_taken.c1.flush", int'(ifid_flush), 0);
        chk_stall("h2_taken.c1", 1);
        tick();
        chk("h2_taken.c2.flush", int'(ifid_flush), 1);
        chk_stall("h2_taken.c2", 0);
        tick();
        idle();
        #1;
        chk("h2_taken.flush_cnt", int'(flush_cnt), 2);
        chk("h2_taken.stall_cnt", int'(stall_cnt), 7);

        // H2 then reset during S1
        beq(5'd10, 5'd0, 1'b0);
        ex_Rw = 10; ex_RegWr = 1; ex_MemtoReg = 1;
        tick();
        idle();
        rst = 1;
        #1;
        chk_stall("rst_s1.c1", 1);
        tick();
        rst = 0;
        #1;
        chk_stall("rst_s1.after", 0);
        chk("rst_s1.stall_cnt", int'(stall_cnt), 0);
        chk("rst_s1.flush_cnt", int'(flush_cnt), 0);
        chk("rst_s1.small_cnt", int'(s_stall_cnt), 0);

        // Five consecutive load-use stalls saturate the 2-bit counter
        id_Ra = 11; id_UsesRa = 1;
        ex_Rw = 11; ex_RegWr = 1; ex_MemtoReg = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        idle();
        #1;
        chk("sat.small_cnt", int'(s_stall_cnt), 3);
        chk("sat.big_cnt", int'(stall_cnt), 5);
        tick();
        chk("sat.small_hold", int'(s_stall_cnt), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Stall/flush sequencer for the ID-resolved branch path of the 5-stage lw/beq pipeline. Detects data hazards on branch operands and load-use hazards, holds PC and IF/ID, and injects ID/EX bubbles for the required number of cycles. Drives the branch operand forwarding selects and flushes IF/ID on a taken branch. Sits in the control stage beside the main decoder and the EX forwarding unit; keeps saturating stall/flush statistics.

## Interface
- CNT_W, 16, width of each statistics counter

- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_Ra, id_Rb  in  5 each  source registers of instruction in ID
- id_Branch  in  1  ID instruction is beq
- id_UsesRa, id_UsesRb  in  1 each  ID instruction reads Ra / Rb
- ex_Rw, mem_Rw  in  5 each  destination register in EX / MEM
- ex_RegWr, ex_MemtoReg, mem_RegWr, mem_MemtoReg  in  1 each  write-enable / load flag per stage
- branch_taken  in  1  beq comparison result in ID
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- idex_bubble  out  1  load NOP controls into ID/EX
- ifid_flush  out  1  zero IF/ID on next edge
- BranchForwardA, BranchForwardB  out  1 each  branch comparator operand from MEM ALU result (1) or register file (0)
- stall_cnt, flush_cnt  out  CNT_W each  saturating statistics

## Operation
- Match terms: mA = id_UsesRa && Rw!=0 && Rw==id_Ra; mB = id_UsesRb && Rw!=0 && Rw==id_Rb; hit = mA||mB, evaluated per stage.
- Hazard classes, checked only in state RUN:
  - H2: id_Branch && ex_RegWr && ex_MemtoReg && hit(ex) → stall now, next state S1.
  - H1a: id_Branch && ex_RegWr && !ex_MemtoReg && hit(ex) → stall now, stay RUN.
  - H1b: id_Branch && mem_RegWr && mem_MemtoReg && hit(mem) → stall now, stay RUN.
  - H1c: !id_Branch && ex_RegWr && ex_MemtoReg && hit(ex) → stall now (load-use), stay RUN.
- Priority H2 > H1a/H1b/H1c; any simultaneous combination including H2 goes to S1.
- S1: stall unconditionally, next state RUN; inputs ignored.
- stall = (state==S1) || any hazard in RUN; pc_stall = ifid_stall = idex_bubble = stall.
- ifid_flush = id_Branch && branch_taken && !stall. Taken branch under stall never flushes.
- BranchForwardA = mem_RegWr && !mem_MemtoReg && mem_Rw!=0 && mem_Rw==id_Ra; BranchForwardB identical on id_Rb. Forwarding is independent of stall; the register file is write-before-read, so no WB path exists.
- stall_cnt +1 per stall cycle, flush_cnt +1 per ifid_flush cycle; both hold at 2^CNT_W-1.

## Timing
- All outputs except counters are combinational from state and inputs, with zero latency.
- State and counters update on the rising clk edge.
- lw→beq dependency costs 2 stall cycles. ALU→beq costs 1. lw→ALU use costs 1. A taken branch costs 1 flush.
- Reset: state RUN, stall_cnt=0, flush_cnt=0. Outputs then follow inputs (all 0 with idle inputs).
- rst asserted in S1: next state RUN, remaining stall abandoned, counters cleared.

## Structure
- Package hazard_pkg holds the state enum {RUN, S1}, the 1-bit encoding, and the default CNT_W.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output q) is instantiated twice.
- Single always_ff for state; hazard decode and outputs in one always_comb.

## Test plan
- lw r1 in EX, beq r1,r2 in ID: stall=1 for 2 cycles (RUN→S1→RUN), then beq proceeds with BranchForwardA=0; stall_cnt=2.
- add r2 in EX, beq r3,r2 in ID: stall 1 cycle. Next cycle add is in MEM: BranchForwardB=1, BranchForwardA=0, stall=0.
- lw r3 in EX, non-branch add using r3 in ID: stall=1 for exactly 1 cycle. Repeat with ex_Rw=0: no stall.
- beq taken with no hazard: ifid_flush=1 for 1 cycle, flush_cnt=1. Same beq with branch_taken=1 during an H2 stall: ifid_flush=0 until the stall ends.
- H2 triggered, rst=1 on the S1 cycle: next cycle state RUN, stall=0 with idle inputs, both counters 0.
- CNT_W=2 with 5 consecutive stall cycles: stall_cnt=3 and holds.
